// File: rtl/mult32x32_req_seq.sv
// Request sequencer for an external 32x32 multiplier FSM.
// Launches one operation at a time and buffers the 64-bit result.
module mult32x32_req_seq #(
  parameter int CNT_W    = 16,
  parameter int WDOG_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             mul_start,
  input  logic             mul_busy,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      mul_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_product,
  output logic [CNT_W-1:0] op_count,
  output logic             proto_err
);

  localparam int WD_W = $clog2(WDOG_MAX + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_MAX);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WD_W-1:0] wdog;
  logic [WD_W-1:0] wdog_nxt;
  logic            accept;
  logic            capture;
  logic            drain;
  logic            wd_inc;
  logic            wd_hit;

  assign in_ready  = (state == IDLE);
  assign mul_start = (state == LAUNCH);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    wdog_nxt  = wdog;
    capture   = 1'b0;
    wd_inc    = 1'b0;
    wd_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        wdog_nxt  = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        wd_inc = 1'b1;
        if (mul_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!mul_busy && (!out_valid || out_ready)) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (mul_busy) begin
          wd_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Backpressure stalls with an idle multiplier do not age the watchdog
    if (wd_inc) begin
      wdog_nxt = wdog + 1'b1;
      if (wdog_nxt == WD_LIM) begin
        wd_hit    = 1'b1;
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wdog        <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      op_count    <= '0;
      proto_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      wdog  <= wdog_nxt;
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      if (capture) begin
        out_valid   <= 1'b1;
        out_product <= mul_product;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
      if (drain) op_count <= op_count + 1'b1;
      if (wd_hit) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult32x32_req_seq.sv
// Bench for mult32x32_req_seq: multiplier stub, directed
// vectors, corner-case sequences and a random scoreboard.
module tb_mult32x32_req_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        mul_start;
  logic        mul_busy;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_product;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic [15:0] op_count;
  logic        proto_err;

  logic        in_ready4;
  logic        mul_start4;
  logic [31:0] mul_a4;
  logic [31:0] mul_b4;
  logic        out_valid4;
  logic [63:0] out_product4;
  logic [3:0]  op_count4;
  logic        proto_err4;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_len = 4;
  int bcnt;

  always #5 clk = ~clk;

  mult32x32_req_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_busy(mul_busy),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product),
    .op_count(op_count), .proto_err(proto_err)
  );

  mult32x32_req_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start4), .mul_busy(mul_busy),
    .mul_a(mul_a4), .mul_b(mul_b4),
    .mul_product(mul_product),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_product(out_product4),
    .op_count(op_count4), .proto_err(proto_err4)
  );

  // Multiplier stub: busy for busy_len cycles after start; product is
  // junk while busy and becomes a*b on the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt        <= 0;
      mul_product <= '0;
    end else if (mul_start) begin
      bcnt        <= busy_len;
      mul_product <= 64'hA5A5_5A5A_DEAD_BEEF;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1)
        mul_product <= {32'h0, mul_a} * {32'h0, mul_b};
    end
  end
  assign mul_busy = (bcnt != 0);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t tbl[6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  // One operation with out_ready held high; lat counts cycles from accept.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] p,
                       output logic st);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      cyc();
      w++;
    end
    chk("op_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    cyc();
    in_valid = 1'b0;
    st  = mul_start;
    lat = 1;
    while (!out_valid && lat < 40) begin
      cyc();
      lat++;
    end
    p = out_product;
  endtask

  initial begin
    int          lat;
    logic [63:0] p;
    logic        st;
    logic        seen;
    int          hs;
    logic [63:0] q[$];
    logic [63:0] e;

    tbl[0] = '{32'd3,         32'd5,         64'd15};
    tbl[1] = '{32'd0,         32'hFFFF_FFFF, 64'd0};
    tbl[2] = '{32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF};
    tbl[3] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
    tbl[4] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_start", mul_start, 1'b0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_product", out_product, 0);
    chk("rst_count", op_count, 0);
    chk("rst_err", proto_err, 1'b0);
    reset = 1'b0;

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p, st);
    chk("single_start", st, 1'b1);
    chk("single_lat", lat, 7);
    chk("single_prod", p, 64'hFFFF_FFFE_0000_0001);
    chk("single_ready_c7", in_ready, 1'b1);
    cyc();
    chk("single_count", op_count, 1);
    chk("single_drained", out_valid, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, lat, p, st);
      chk($sformatf("tbl%0d_lat", i), lat, 7);
      chk($sformatf("tbl%0d_prod", i), p, tbl[i].p);
      chk($sformatf("tbl%0d_mula", i), mul_a, tbl[i].a);
    end
    cyc();
    chk("tbl_count", op_count, 7);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_op(i, 3, lat, p, st);
      if (i == 15) chk("wrap_c15", op_count4, 4'd15);
    end
    cyc();
    chk("wrap_cnt4", op_count4, 4'd0);
    chk("wrap_cnt16", op_count, 16);

    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t <= 22; t++) begin
      in_valid  = (t == 0 || t == 7);
      in_a      = (t == 0) ? 32'd3 : 32'd7;
      in_b      = (t == 0) ? 32'd5 : 32'd9;
      out_ready = (t >= 20);
      if (t == 7) begin
        chk("bp_ready_c7", in_ready, 1'b1);
        chk("bp_valid_c7", out_valid, 1'b1);
        chk("bp_prod_c7", out_product, 15);
      end
      if (t == 19) begin
        chk("bp_stall_ready", in_ready, 1'b0);
        chk("bp_hold_prod", out_product, 15);
      end
      if (t == 20) begin
        chk("bp_prod_c20", out_product, 15);
        chk("bp_count_c20", op_count, 0);
      end
      if (t == 21) begin
        chk("bp_valid_c21", out_valid, 1'b1);
        chk("bp_prod_c21", out_product, 63);
        chk("bp_count_c21", op_count, 1);
      end
      if (t == 22) begin
        chk("bp_valid_c22", out_valid, 1'b0);
        chk("bp_count_c22", op_count, 2);
      end
      cyc();
    end
    in_valid = 1'b0;

    do_reset();
    busy_len  = 0;
    out_ready = 1'b1;
    in_a = 32'd4; in_b = 32'd4; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 1; t < 16; t++) begin
      cyc();
      seen = seen | out_valid;
    end
    chk("wd_err_c16", proto_err, 1'b0);
    chk("wd_ready_c16", in_ready, 1'b0);
    cyc();
    chk("wd_err_c17", proto_err, 1'b1);
    chk("wd_ready_c17", in_ready, 1'b1);
    chk("wd_no_out", seen | out_valid, 1'b0);
    busy_len = 4;
    do_op(32'd10, 32'd11, lat, p, st);
    chk("wd_after_prod", p, 110);
    chk("wd_sticky", proto_err, 1'b1);

    in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int t = 1; t < 4; t++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_in_ready", in_ready, 1'b1);
    chk("mid_start", mul_start, 1'b0);
    chk("mid_mul_a", mul_a, 0);
    chk("mid_mul_b", mul_b, 0);
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_product", out_product, 0);
    chk("mid_count", op_count, 0);
    chk("mid_err", proto_err, 1'b0);
    do_op(32'd2, 32'd3, lat, p, st);
    chk("mid_next_lat", lat, 7);
    chk("mid_next_prod", p, 6);

    do_reset();
    hs = 0;
    for (int t = 0; t < 440; t++) begin
      chk("rnd_count", op_count, hs);
      if (t < 400) begin
        in_valid  = $urandom_range(0, 1);
        out_ready = $urandom_range(0, 3) != 0;
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      in_a     = $urandom;
      in_b     = $urandom;
      busy_len = $urandom_range(1, 6);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk("rnd_prod", out_product, e);
        end
        hs++;
      end
      if (in_valid && in_ready)
        q.push_back({32'h0, in_a} * {32'h0, in_b});
      cyc();
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_no_err", proto_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult32x32_req_seq.md
MULT32X32_REQ_SEQ -- requirements
Module: mult32x32_req_seq

Interface
REQ-001 Parameter CNT_W, default 16: width of op_count.
REQ-002 Parameter WDOG_MAX, default 15: cycles allowed in WAIT_ACK plus WAIT_DONE before a protocol error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 in_a  input  32  multiplicand, unsigned.
REQ-008 in_b  input  32  multiplier, unsigned.
REQ-009 mul_start  output  1  start pulse to the multiplier FSM.
REQ-010 mul_busy  input  1  busy from the multiplier FSM.
REQ-011 mul_a  output  32  held multiplicand to the multiplier datapath.
REQ-012 mul_b  output  32  held multiplier to the multiplier datapath.
REQ-013 mul_product  input  64  registered product from the multiplier datapath.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_product  output  64  captured 64-bit product.
REQ-017 op_count  output  CNT_W  completed output handshakes.
REQ-018 proto_err  output  1  sticky watchdog error.

Function
REQ-019 The block SHALL use 4 states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; an accept is in_valid && in_ready.
REQ-021 On accept, the block SHALL latch in_a/in_b into mul_a/mul_b and go to LAUNCH; no accept leaves IDLE unchanged.
REQ-022 mul_a/mul_b SHALL remain stable from LAUNCH until the next accept.
REQ-023 mul_start SHALL be 1 only in LAUNCH, exactly one cycle; LAUNCH always goes to WAIT_ACK.
REQ-024 WAIT_ACK: mul_busy=1 -> WAIT_DONE; else stay.
REQ-025 WAIT_DONE: when mul_busy=0 and (out_valid=0 or out_ready=1), the block SHALL capture mul_product into out_product, set out_valid, go to IDLE; otherwise stay (product held by idle multiplier).
REQ-026 Latency: accept in cycle 0 -> mul_start in cycle 1 -> out_valid=1 in cycle 7 with a 4-busy-cycle multiplier; in_ready=1 again in cycle 7.
REQ-027 A new operand pair SHALL be acceptable while out_valid=1 (result buffer independent of the operation in flight).
REQ-028 out_valid SHALL clear on out_valid && out_ready unless a capture occurs in the same cycle, in which case out_valid stays 1 with the new product.
REQ-029 op_count SHALL increment by 1 on each out_valid && out_ready, wrapping from all-ones to 0.
REQ-030 A watchdog counter SHALL clear in LAUNCH and increment each cycle in WAIT_ACK/WAIT_DONE; excluding cycles stalled by REQ-025 backpressure with mul_busy=0.
REQ-031 On the watchdog reaching WDOG_MAX, the block SHALL set proto_err, discard the operation (no output), and return to IDLE.
REQ-032 proto_err SHALL stay 1 until reset; operation continues normally after it is set.

Reset
REQ-033 Reset SHALL be sampled on the clock edge only and SHALL override all other events in that cycle.
REQ-034 After reset: state IDLE, in_ready=1, mul_start=0, mul_a=mul_b=0, out_valid=0, out_product=0, op_count=0, proto_err=0, watchdog=0.
REQ-035 Reset mid-operation SHALL drop the operation in flight and any pending result with no output handshake.

Verification
REQ-036 Single op: a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1 -> out_product=0xFFFFFFFE00000001 in cycle 7, op_count=1.
REQ-037 Backpressure: two ops (3x5, 7x9) back-to-back, out_ready=0 until cycle 20 -> second op stalls in WAIT_DONE; outputs 15 then 63 in order, none lost.
REQ-038 Simultaneous drain/capture: out_ready asserted in the cycle the second capture occurs -> out_valid remains 1, out_product=63, op_count increments once.
REQ-039 Watchdog: mul_busy tied 0 -> proto_err=1 after 15 cycles in WAIT_ACK, no out_valid, in_ready=1 next cycle.
REQ-040 Reset at cycle 4 of an op -> all outputs at REQ-034 values next cycle; no out_valid; next op a=2,b=3 returns 6.
REQ-041 op_count wrap: CNT_W=4, 16 handshakes -> op_count=0.
